// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG scan-byte feeder: marker codes, byte-FSM states
// and the bit-reversal helper used when packing bytes LSB-first.
package jpeg_pkg;

    localparam logic [7:0] MRK_STUFF = 8'h00;
    localparam logic [7:0] MRK_RST0  = 8'hD0;
    localparam logic [7:0] MRK_RST7  = 8'hD7;
    localparam logic [7:0] MRK_EOI   = 8'hD9;
    localparam logic [7:0] MRK_FILL  = 8'hFF;

    typedef enum logic [1:0] {
        ST_DATA    = 2'd0,
        ST_FF_PEND = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERR     = 2'd3
    } byte_state_e;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/jpeg_byte_unstuffer.sv
// Byte-level scan FSM: strips 0xFF00 stuffing, drops RSTn markers, detects EOI
// and illegal markers. Packing and output buffering live in the parent.
module jpeg_byte_unstuffer
    import jpeg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       accept_i,
    input  logic [7:0] byte_i,
    output logic       active_o,
    output logic       pack_valid_o,
    output logic [7:0] pack_byte_o,
    output logic       flush_o,
    output logic       discard_o,
    output logic       rst_seen_o,
    output logic       marker_err_o
);

    byte_state_e state_q, state_d;
    logic        rst_seen_q, rst_seen_d;
    logic        marker_err_q, marker_err_d;

    // State and flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_DATA;
            rst_seen_q   <= 1'b0;
            marker_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_seen_q   <= rst_seen_d;
            marker_err_q <= marker_err_d;
        end
    end

    // Next-state decode of the accepted byte.
    always_comb begin
        state_d      = state_q;
        pack_valid_o = 1'b0;
        pack_byte_o  = byte_i;
        flush_o      = 1'b0;
        discard_o    = 1'b0;
        rst_seen_d   = 1'b0;
        marker_err_d = marker_err_q;
        case (state_q)
            ST_DATA: begin
                if (accept_i) begin
                    if (byte_i == MRK_FILL) begin
                        state_d = ST_FF_PEND;
                    end else begin
                        pack_valid_o = 1'b1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_FF_PEND: begin
                if (accept_i) begin
                    if (byte_i == MRK_STUFF) begin
                        pack_valid_o = 1'b1;
                        pack_byte_o  = MRK_FILL;
                        state_d      = ST_DATA;
                    end else if (byte_i == MRK_FILL) begin
                        state_d = ST_FF_PEND;
                    end else if (byte_i >= MRK_RST0 && byte_i <= MRK_RST7) begin
                        rst_seen_d = 1'b1;
                        state_d    = ST_DATA;
                    end else if (byte_i == MRK_EOI) begin
                        flush_o = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        marker_err_d = 1'b1;
                        discard_o    = 1'b1;
                        state_d      = ST_ERR;
                    end
                end else begin
                    state_d = ST_FF_PEND;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    assign active_o     = (state_q == ST_DATA) || (state_q == ST_FF_PEND);
    assign rst_seen_o   = rst_seen_q;
    assign marker_err_o = marker_err_q;

endmodule

// File: rtl/jpeg_bitstream_feeder.sv
// Feeds unstuffed JPEG scan bits to the decoder: packs bit-reversed bytes into
// OUT_W-bit words and hands them off through a one-word buffer on `request`.
`ifndef IN_BUS_WIDTH
`define IN_BUS_WIDTH 32
`endif

module jpeg_bitstream_feeder
    import jpeg_pkg::*;
#(
    parameter int OUT_W = `IN_BUS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             request,
    output logic [OUT_W-1:0] data_in,
    output logic             valid_in,
    output logic             rst_seen,
    output logic             eoi_done,
    output logic             marker_err
);

    localparam int NB  = OUT_W / 8;
    localparam int K_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [K_W-1:0] KMAX = K_W'(NB - 1);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             acc_full_q, acc_full_d;
    logic [OUT_W-1:0] obuf_q, obuf_d;
    logic             obuf_full_q, obuf_full_d;
    logic             eoi_pend_q, eoi_pend_d;
    logic             eoi_done_q, eoi_done_d;

    logic       active_s, accept_s, pack_valid_s, flush_s, discard_s;
    logic [7:0] pack_byte_s;
    logic       take_s, word_done_s, obuf_free_s;

    // Gating on rst keeps byte_ready low while reset is held.
    assign byte_ready = !rst && active_s && !acc_full_q;
    assign accept_s   = byte_valid && byte_ready;
    assign valid_in   = request && obuf_full_q;
    assign take_s     = valid_in;
    assign data_in    = obuf_full_q ? obuf_q : '0;
    assign eoi_done   = eoi_done_q;

    jpeg_byte_unstuffer u_unstuffer (
        .clk_i        (clk),
        .rst_i        (rst),
        .accept_i     (accept_s),
        .byte_i       (byte_in),
        .active_o     (active_s),
        .pack_valid_o (pack_valid_s),
        .pack_byte_o  (pack_byte_s),
        .flush_o      (flush_s),
        .discard_o    (discard_s),
        .rst_seen_o   (rst_seen),
        .marker_err_o (marker_err)
    );

    // Packing, EOI padding and output-buffer handoff.
    always_comb begin
        acc_d       = acc_q;
        k_d         = k_q;
        word_done_s = 1'b0;
        eoi_pend_d  = eoi_pend_q;
        if (acc_full_q) begin
            word_done_s = 1'b1;
        end else if (pack_valid_s) begin
            acc_d[8*k_q +: 8] = bitrev8(pack_byte_s);
            if (k_q == KMAX) begin
                k_d         = '0;
                word_done_s = 1'b1;
            end else begin
                k_d = k_q + K_W'(1);
            end
        end else if (flush_s) begin
            eoi_pend_d = 1'b1;
            if (k_q != '0) begin
                for (int i = 0; i < NB; i++) begin
                    if (i >= int'(k_q)) begin
                        acc_d[8*i +: 8] = MRK_FILL;
                    end else begin
                        acc_d[8*i +: 8] = acc_q[8*i +: 8];
                    end
                end
                k_d         = '0;
                word_done_s = 1'b1;
            end else begin
                k_d = k_q;
            end
        end else if (discard_s) begin
            k_d = '0;
        end else begin
            k_d = k_q;
        end

        obuf_free_s = !obuf_full_q || take_s;
        acc_full_d  = word_done_s && !obuf_free_s;
        if (word_done_s && obuf_free_s) begin
            obuf_d      = acc_d;
            obuf_full_d = 1'b1;
        end else if (take_s) begin
            obuf_d      = '0;
            obuf_full_d = 1'b0;
        end else begin
            obuf_d      = obuf_q;
            obuf_full_d = obuf_full_q;
        end

        // EOI completes only once nothing remains buffered anywhere.
        eoi_done_d = eoi_done_q || (eoi_pend_q && !obuf_full_q && !acc_full_q);
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            k_q         <= '0;
            acc_full_q  <= 1'b0;
            obuf_q      <= '0;
            obuf_full_q <= 1'b0;
            eoi_pend_q  <= 1'b0;
            eoi_done_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            k_q         <= k_d;
            acc_full_q  <= acc_full_d;
            obuf_q      <= obuf_d;
            obuf_full_q <= obuf_full_d;
            eoi_pend_q  <= eoi_pend_d;
            eoi_done_q  <= eoi_done_d;
        end
    end

endmodule
